// File: rtl/flatten_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flatten_packer: packs IN_WIDTH-bit feature beats into a NUM_INPUTS-bit   |
// | vector for the dense/argmax classifier. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module flatten_packer #(
  parameter int NUM_INPUTS = 196,
  parameter int IN_WIDTH   = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_valid,
  input  logic [IN_WIDTH-1:0]                      in_bits,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic [NUM_INPUTS-1:0]                    out_vector,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     frame_error,
  output logic [$clog2(NUM_INPUTS/IN_WIDTH+1)-1:0] beat_count,
  output logic [7:0]                               frames_done
);

  localparam int BEATS = NUM_INPUTS / IN_WIDTH;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] c_LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_frame_error;
  logic [NUM_INPUTS-1:0] r_vector;
  logic [CW-1:0]         r_beat_count;
  logic [7:0]            r_frames_done;

  logic w_accept;
  logic w_final_beat;

  assign w_accept     = in_valid & r_in_ready;
  assign w_final_beat = (r_beat_count == c_LAST_BEAT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_FILL;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_frame_error <= 1'b0;
      r_vector      <= '0;
      r_beat_count  <= '0;
      r_frames_done <= 8'd0;
    end else begin
      r_frame_error <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_beat_count == CW'(b)) begin
                r_vector[b*IN_WIDTH +: IN_WIDTH] <= in_bits;
              end
            end
            if (w_final_beat) begin
              // Full frame is delivered even when the end marker is missing.
              r_state       <= S_FULL;
              r_in_ready    <= 1'b0;
              r_out_valid   <= 1'b1;
              r_beat_count  <= '0;
              r_frame_error <= ~in_last;
            end else if (in_last) begin
              // Short frame: the clear below overrides this beat's write.
              r_beat_count  <= '0;
              r_vector      <= '0;
              r_frame_error <= 1'b1;
            end else begin
              r_beat_count <= r_beat_count + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (r_out_valid && out_ready) begin
            r_state       <= S_FILL;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_vector      <= '0;
            r_frames_done <= r_frames_done + 8'd1;
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_vector  = r_vector;
  assign out_valid   = r_out_valid;
  assign frame_error = r_frame_error;
  assign beat_count  = r_beat_count;
  assign frames_done = r_frames_done;

endmodule
`default_nettype wire
